// File: rtl/forward_unit_pkg.sv
// Shared pipeline types for the operand forwarding unit.
// In-flight slot layout and bypass select encoding.
package forward_unit_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } inflight_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator and youngest-first bypass mux.
// x0 and unused sources always read the register file.
module fwd_match #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [XLEN-1:0]   ex_data,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [XLEN-1:0]   wb_data,
    output logic [1:0]        sel,
    output logic [XLEN-1:0]   data,
    output logic              ex_hit
);
    import forward_unit_pkg::*;

    logic     src_ok;
    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel_e;

    assign src_ok  = rs_used && (rs != '0);
    assign ex_hit  = src_ok && ex_wr  && (ex_rd  == rs);
    assign mem_hit = src_ok && mem_wr && (mem_rd == rs);
    assign wb_hit  = src_ok && wb_wr  && (wb_rd  == rs);

    // Youngest producer wins: EX, then MEM, then WB, else RF.
    always_comb begin
        sel_e = FWD_RF;
        data  = rf_data;
        if (ex_hit) begin
            sel_e = FWD_EX;
            data  = ex_data;
        end else if (mem_hit) begin
            sel_e = FWD_MEM;
            data  = mem_data;
        end else if (wb_hit) begin
            sel_e = FWD_WB;
            data  = wb_data;
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/forward_unit.sv
// Operand bypass selection and load-use stall detection.
// Tracks EX/MEM/WB destinations in a shadow pipeline.
module forward_unit #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              branch_taken_EXB,
    input  logic              flush_EXB,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [XLEN-1:0]   fwd_rs1_data,
    output logic [XLEN-1:0]   fwd_rs2_data,
    output logic              no_forwarding_data,
    output logic [CNT_W-1:0]  loaduse_cnt
);
    import forward_unit_pkg::*;

    inflight_t ex_q;
    inflight_t mem_q;
    inflight_t wb_q;
    logic      rs1_ex_hit;
    logic      rs2_ex_hit;
    logic      use_hazard;

    // Shadow pipeline shifts every cycle; a flush injects a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            loaduse_cnt <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (flush_EXB)
                ex_q <= '0;
            else
                ex_q <= '{valid:   id_valid,
                          rd:      id_rd,
                          we:      id_rd_we,
                          is_load: id_is_load};
            if (no_forwarding_data &&
                (loaduse_cnt != {CNT_W{1'b1}}))
                loaduse_cnt <= loaduse_cnt + 1'b1;
        end
    end

    fwd_match #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs1 (
        .rs       (id_rs1),
        .rs_used  (id_rs1_used),
        .ex_wr    (ex_q.valid & ex_q.we),
        .ex_rd    (ex_q.rd),
        .mem_wr   (mem_q.valid & mem_q.we),
        .mem_rd   (mem_q.rd),
        .wb_wr    (wb_q.valid & wb_q.we),
        .wb_rd    (wb_q.rd),
        .rf_data  (rf_rs1_data),
        .ex_data  (ex_fwd_data),
        .mem_data (mem_fwd_data),
        .wb_data  (wb_fwd_data),
        .sel      (fwd_rs1_sel),
        .data     (fwd_rs1_data),
        .ex_hit   (rs1_ex_hit)
    );

    fwd_match #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs2 (
        .rs       (id_rs2),
        .rs_used  (id_rs2_used),
        .ex_wr    (ex_q.valid & ex_q.we),
        .ex_rd    (ex_q.rd),
        .mem_wr   (mem_q.valid & mem_q.we),
        .mem_rd   (mem_q.rd),
        .wb_wr    (wb_q.valid & wb_q.we),
        .wb_rd    (wb_q.rd),
        .rf_data  (rf_rs2_data),
        .ex_data  (ex_fwd_data),
        .mem_data (mem_fwd_data),
        .wb_data  (wb_fwd_data),
        .sel      (fwd_rs2_sel),
        .data     (fwd_rs2_data),
        .ex_hit   (rs2_ex_hit)
    );

    // Load data is not ready until MEM; a wrong-path consumer is never held.
    always_comb begin
        use_hazard = id_valid && (rs1_ex_hit || rs2_ex_hit)
                     && ex_q.is_load;
        no_forwarding_data = use_hazard && !branch_taken_EXB;
    end

endmodule
